// File: rtl/ucdp_sfifo_wrarb.sv
// -----------------------------------------------------------------------------
// ucdp_sfifo_wrarb
//
// Packet-locking round-robin write arbiter in front of a synchronous FIFO.
// Several requesters each present a word stream. The arbiter grants one of
// them and keeps that grant for the whole packet, up to and including the
// word flagged "last". It then returns to IDLE for one arbitration cycle
// before the next owner is chosen.
//
// Parameters
//   dwidth_p  : data width per requester and on the FIFO write port
//   nreq_p    : number of requesters (2..16)
//   iwidth_p  : requester index width
//
// Ports
//   src_clk_i       in   clock
//   src_rst_an_i    in   asynchronous reset, active low
//   req_valid_i     in   [nreq_p]            per-requester word valid
//   req_data_i      in   [nreq_p*dwidth_p]   requester k at [k*dwidth_p +: dwidth_p]
//   req_last_i      in   [nreq_p]            last word of a packet
//   req_ready_o     out  [nreq_p]            word accepted when valid & ready
//   fifo_wr_en_o    out                      FIFO write strobe
//   fifo_wr_data_o  out  [dwidth_p]          FIFO write data
//   fifo_wr_full_i  in                       FIFO full flag
//   grant_o         out  [nreq_p]            one-hot current owner, 0 when idle
//   grant_idx_o     out  [iwidth_p]          index of current / most recent owner
//   busy_o          out                      high while a packet is locked
// -----------------------------------------------------------------------------
module ucdp_sfifo_wrarb #(
    parameter int unsigned dwidth_p = 8,
    parameter int unsigned nreq_p   = 4,
    parameter int unsigned iwidth_p = $clog2(nreq_p)
) (
    input  logic                         src_clk_i,
    input  logic                         src_rst_an_i,
    input  logic [nreq_p-1:0]            req_valid_i,
    input  logic [nreq_p*dwidth_p-1:0]   req_data_i,
    input  logic [nreq_p-1:0]            req_last_i,
    output logic [nreq_p-1:0]            req_ready_o,
    output logic                         fifo_wr_en_o,
    output logic [dwidth_p-1:0]          fifo_wr_data_o,
    input  logic                         fifo_wr_full_i,
    output logic [nreq_p-1:0]            grant_o,
    output logic [iwidth_p-1:0]          grant_idx_o,
    output logic                         busy_o
);

    typedef enum logic {
        IDLE_S = 1'b0,
        LOCK_S = 1'b1
    } state_t;

    localparam logic [iwidth_p-1:0] MaxIdx = iwidth_p'(nreq_p - 1);

    state_t              state_q, state_d;
    logic [nreq_p-1:0]   grant_q, grant_d;
    logic [iwidth_p-1:0] last_q,  last_d;

    // Increment with explicit wrap so non-power-of-two requester counts
    // never produce an out-of-range index.
    function automatic logic [iwidth_p-1:0] next_idx(input logic [iwidth_p-1:0] idx);
        logic [iwidth_p-1:0] res;
        if (idx == MaxIdx) begin
            res = '0;
        end else begin
            res = idx + iwidth_p'(1);
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin search: walk nreq_p positions starting just after the
    // previous owner; the first valid requester found wins. The previous
    // owner itself is visited last, so it only wins when nobody else asks.
    // -------------------------------------------------------------------------
    logic                arb_found;
    logic [iwidth_p-1:0] arb_idx;
    logic [iwidth_p-1:0] arb_cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_q;
        arb_cand  = last_q;
        for (int k = 0; k < nreq_p; k++) begin
            arb_cand = next_idx(arb_cand);
            if (!arb_found && req_valid_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Owner view: while locked the owner index is last_q.
    // -------------------------------------------------------------------------
    logic                owner_valid;
    logic                owner_last;
    logic [dwidth_p-1:0] owner_data;

    always_comb begin
        owner_valid = req_valid_i[last_q];
        owner_last  = req_last_i[last_q];
        owner_data  = '0;
        for (int k = 0; k < nreq_p; k++) begin
            if (iwidth_p'(k) == last_q) begin
                owner_data = req_data_i[k*dwidth_p +: dwidth_p];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath outputs. IDLE never accepts a word, which
    // makes every packet pay exactly one arbitration cycle and keeps
    // back-to-back packets from different (or the same) owner apart.
    // -------------------------------------------------------------------------
    logic wr_en;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        wr_en          = 1'b0;
        req_ready_o    = '0;
        fifo_wr_data_o = '0;

        case (state_q)
            IDLE_S: begin
                if (arb_found) begin
                    state_d          = LOCK_S;
                    last_d           = arb_idx;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                end
            end
            LOCK_S: begin
                // A full FIFO stalls the owner: no ready, no write, state kept.
                req_ready_o[last_q] = ~fifo_wr_full_i;
                wr_en               = owner_valid & ~fifo_wr_full_i;
                fifo_wr_data_o      = owner_data;
                if (wr_en && owner_last) begin
                    state_d = IDLE_S;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE_S;
                grant_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. last_q resets to the highest index so requester 0 is
    // first in line after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
        if (!src_rst_an_i) begin
            state_q <= IDLE_S;
            grant_q <= '0;
            last_q  <= MaxIdx;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign fifo_wr_en_o = wr_en;
    assign grant_o      = grant_q;
    assign grant_idx_o  = last_q;
    assign busy_o       = (state_q == LOCK_S);

endmodule
